// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and frame constants shared by spi_master and its bench
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int FRAME_LEN = 24;
    localparam logic RWB_READ = 1'b1;
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: host request/response and serial pins of spi_master
// SPI_MASTER_ABORT_EN adds the abort/aborted pair.
interface spi_master_if;
    import spi_pkg::*;
    logic              start;
    logic              rwb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              sclk;
    logic              sdi;
    logic              csz;
    logic              sdo;
`ifdef SPI_MASTER_ABORT_EN
    logic              abort;
    logic              aborted;
    modport master (input start, rwb, addr, wdata, sdo, abort,
                    output busy, done, rdata, sclk, sdi, csz, aborted);
    modport slave (output start, rwb, addr, wdata, sdo, abort,
                   input busy, done, rdata, sclk, sdi, csz, aborted);
`else
    modport master (input start, rwb, addr, wdata, sdo,
                    output busy, done, rdata, sclk, sdi, csz);
    modport slave (output start, rwb, addr, wdata, sdo,
                   input busy, done, rdata, sclk, sdi, csz);
`endif
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period divider producing sclk and its rise/fall strobes
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_shift,
    input  logic i_clr,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);
    logic [7:0] r_cnt;
    logic       r_sclk;
    assign o_tick = i_run && r_cnt == 8'(CLK_DIV - 1);
    assign o_rise = o_tick && i_shift && !r_sclk;
    assign o_fall = o_tick && i_shift && r_sclk;
    assign o_sclk = r_sclk;
    always_ff @(posedge clk) begin
        if (reset || i_clr || !i_run) r_cnt <= '0;
        else r_cnt <= o_tick ? '0 : r_cnt + 8'd1;
        if (reset || i_clr) r_sclk <= 1'b0;
        else if (o_tick && i_shift) r_sclk <= !r_sclk;
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI frame engine (7-bit addr, rwb, 16-bit data)
// SPI_MASTER_ABORT_EN adds abort/aborted for cancelling a frame in flight.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CSZ_GAP = 2
) (
    input logic          clk,
    input logic          reset,
    spi_master_if.master bus
);
    state_t               r_state, w_next;
    logic [FRAME_LEN-2:0] r_sr;
    logic [DATA_W-1:0]    r_rx, r_rdata;
    logic [4:0]           r_bit;
    logic                 r_sdi, r_rwb, r_done;
    logic                 w_tick, w_rise, w_fall, w_sclk, w_active, w_abort, w_accept, w_end;

    assign w_active = r_state inside {SETUP, SHIFT, HOLD};
    assign w_accept = r_state == IDLE && bus.start;
    assign w_end    = r_state == HOLD && w_tick && !w_abort;
`ifdef SPI_MASTER_ABORT_EN
    logic r_aborted;
    assign w_abort     = w_active && bus.abort;
    assign bus.aborted = r_aborted;
    always_ff @(posedge clk) r_aborted <= !reset && w_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign bus.busy  = r_state != IDLE;
    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;
    assign bus.sclk  = w_sclk;
    assign bus.sdi   = r_sdi;
    assign bus.csz   = !w_active;

    // Any state change restarts the divider so each state times from zero.
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .i_run   (r_state != IDLE),
        .i_shift (r_state == SHIFT),
        .i_clr   (w_next != r_state),
        .o_tick  (w_tick),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_sclk  (w_sclk)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? SETUP : IDLE;
            SETUP:   w_next = w_tick ? SHIFT : SETUP;
            SHIFT:   w_next = (w_fall && r_bit == 5'(FRAME_LEN - 1)) ? HOLD : SHIFT;
            HOLD:    w_next = w_tick ? GAP : HOLD;
            GAP:     w_next = (w_tick && r_bit == 5'(CSZ_GAP - 1)) ? IDLE : GAP;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = GAP;
    end

    // r_bit counts falling edges in SHIFT and half-periods in GAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '1;
            r_sdi   <= 1'b1;
            r_rwb   <= 1'b0;
            r_bit   <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_end;
            r_bit   <= (w_next != r_state) ? '0 :
                       (w_fall || (r_state == GAP && w_tick)) ? r_bit + 5'd1 : r_bit;
            if (w_rise) r_rx <= {r_rx[DATA_W-2:0], bus.sdo};
            if (w_end && r_rwb == RWB_READ) r_rdata <= r_rx;
            if (w_accept) begin
                r_rwb <= bus.rwb;
                r_sdi <= bus.addr[ADDR_W-1];
                r_sr  <= {bus.addr[ADDR_W-2:0], bus.rwb,
                          bus.rwb == RWB_READ ? {DATA_W{1'b1}} : bus.wdata};
            end else if (w_abort) begin
                r_sdi <= 1'b1;
            end else if (w_fall) begin
                r_sdi <= r_sr[FRAME_LEN-2];
                r_sr  <= {r_sr[FRAME_LEN-3:0], 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench; u0 runs CLK_DIV=4, u1 runs CLK_DIV=2
// Abort checks are built only when SPI_MASTER_ABORT_EN is defined.
module tb_spi_master;
    typedef struct {
        int          inst;
        logic [23:0] frame;
        logic [15:0] rdata;
    } exp_t;
    localparam int CD0 = 4;
    localparam int CD1 = 2;
    localparam int GAP_HP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [1:0] start_v = '0, rwb_v = '0, sdo_v = '0;
    logic [1:0][6:0] addr_v = '0;
    logic [1:0][15:0] wdata_v = '0, slave_v = '0, rdata_w;
    logic [1:0] busy_w, done_w, sclk_w, sdi_w, csz_w;
    int rise_cnt[2], fall_cnt[2], done_cnt[2], last_fall[2], last_rise[2], last_sclk[2];
    logic [23:0] cap[2];
    logic prev_csz[2] = '{1'b1, 1'b1};
    logic prev_sclk[2] = '{1'b0, 1'b0};
    logic have_rise[2] = '{1'b0, 1'b0};
    int cd[2] = '{CD0, CD1};

    spi_master_if bus0();
    spi_master_if bus1();
    spi_master #(.CLK_DIV(CD0), .CSZ_GAP(GAP_HP)) u0 (.clk(clk), .reset(rst), .bus(bus0));
    spi_master #(.CLK_DIV(CD1), .CSZ_GAP(GAP_HP)) u1 (.clk(clk), .reset(rst), .bus(bus1));

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus0.rwb   = rwb_v[0];
    assign bus1.rwb   = rwb_v[1];
    assign bus0.addr  = addr_v[0];
    assign bus1.addr  = addr_v[1];
    assign bus0.wdata = wdata_v[0];
    assign bus1.wdata = wdata_v[1];
    assign bus0.sdo   = sdo_v[0];
    assign bus1.sdo   = sdo_v[1];
    assign busy_w  = {bus1.busy, bus0.busy};
    assign done_w  = {bus1.done, bus0.done};
    assign sclk_w  = {bus1.sclk, bus0.sclk};
    assign sdi_w   = {bus1.sdi, bus0.sdi};
    assign csz_w   = {bus1.csz, bus0.csz};
    assign rdata_w = {bus1.rdata, bus0.rdata};
`ifdef SPI_MASTER_ABORT_EN
    logic [1:0] abort_v = '0, aborted_w;
    assign bus0.abort = abort_v[0];
    assign bus1.abort = abort_v[1];
    assign aborted_w  = {bus1.aborted, bus0.aborted};
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s u%0d: got %0h expected %0h", name, i, act, req);
        end
    endtask

    // Monitor and slave model: track csz/sclk edges, capture sdi at rises,
    // drive sdo for the next rise, and pop the scoreboard on every done.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (csz_w[i] === 1'b0 && prev_csz[i] === 1'b1) begin
                if (have_rise[i]) begin
                    n_vec++;
                    if (cyc - last_rise[i] < GAP_HP * cd[i]) begin
                        n_err++;
                        $display("FAIL csz_gap u%0d: got %0d cycles required >= %0d",
                                 i, cyc - last_rise[i], GAP_HP * cd[i]);
                    end
                end
                rise_cnt[i] = 0;
                cap[i] = '0;
                last_fall[i] = cyc;
                fall_cnt[i]++;
            end
            if (csz_w[i] === 1'b1 && prev_csz[i] === 1'b0) begin
                last_rise[i] = cyc;
                have_rise[i] = 1'b1;
            end
            if (sclk_w[i] === 1'b1 && prev_sclk[i] === 1'b0) begin
                cap[i] = {cap[i][22:0], sdi_w[i]};
                rise_cnt[i]++;
                if (rise_cnt[i] == 2) chk("sclk_period", i, cyc - last_sclk[i], 2 * cd[i]);
                last_sclk[i] = cyc;
            end
            if (done_w[i] === 1'b1) begin
                done_cnt[i]++;
                if (exp_q.size() == 0) chk("unexpected_done_queue", i, exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("done_inst", i, i, e.inst);
                    chk("frame_bits", i, cap[i], e.frame);
                    chk("rise_count", i, rise_cnt[i], 24);
                    chk("rdata", i, rdata_w[i], e.rdata);
                    chk("done_latency", i, cyc - last_fall[i], 50 * cd[i]);
                end
            end
            prev_csz[i] = csz_w[i];
            prev_sclk[i] = sclk_w[i];
            sdo_v[i] = (rise_cnt[i] >= 8 && rise_cnt[i] < 24) ? slave_v[i][23 - rise_cnt[i]] : 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy_w[i] !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        if (n == 1000) chk("idle_timeout", i, busy_w[i], 0);
    endtask

    task automatic wait_done(input int i, input int target);
        int n = 0;
        while (done_cnt[i] < target && n < 2000) begin
            tick();
            n++;
        end
        if (n == 2000) chk("done_timeout", i, done_cnt[i], target);
    endtask

    task automatic wait_rise(input int i, input int k);
        int n = 0;
        while (rise_cnt[i] != k && n < 2000) begin
            tick();
            n++;
        end
        if (n == 2000) chk("rise_timeout", i, rise_cnt[i], k);
    endtask

    task automatic push(input int i, input logic [23:0] fr, input logic [15:0] rd);
        exp_t x;
        x.inst = i;
        x.frame = fr;
        x.rdata = rd;
        exp_q.push_back(x);
    endtask

    task automatic send(input int i, input logic rw, input logic [6:0] a, input logic [15:0] wd,
                        input logic [15:0] sl, input logic [23:0] fr, input logic [15:0] rd);
        wait_idle(i);
        rwb_v[i] = rw;
        addr_v[i] = a;
        wdata_v[i] = wd;
        slave_v[i] = sl;
        start_v[i] = 1'b1;
        push(i, fr, rd);
        tick();
        start_v[i] = 1'b0;
        chk("csz_after_start", i, csz_w[i], 0);
        chk("busy_after_start", i, busy_w[i], 1);
        chk("sdi_first_bit", i, sdi_w[i], a[6]);
    endtask

    task automatic frame(input int i, input logic rw, input logic [6:0] a, input logic [15:0] wd,
                         input logic [15:0] sl, input logic [23:0] fr, input logic [15:0] rd);
        int target = done_cnt[i] + 1;
        send(i, rw, a, wd, sl, fr, rd);
        wait_done(i, target);
    endtask

    initial begin
        int base_f, base_d, n;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset_csz", i, csz_w[i], 1);
            chk("reset_sclk", i, sclk_w[i], 0);
            chk("reset_sdi", i, sdi_w[i], 1);
            chk("reset_busy", i, busy_w[i], 0);
            chk("reset_done", i, done_w[i], 0);
            chk("reset_rdata", i, rdata_w[i], 16'h0000);
        end
        rst = 1'b0;
        tick();
        frame(0, 1'b0, 7'h15, 16'hA5C3, 16'hBEEF, 24'h2AA5C3, 16'h0000);
        frame(0, 1'b1, 7'h7F, 16'h0000, 16'h1234, 24'hFFFFFF, 16'h1234);
        frame(0, 1'b0, 7'h03, 16'h0F0F, 16'hFFFF, 24'h060F0F, 16'h1234);

        wait_idle(0);
        base_f = fall_cnt[0];
        base_d = done_cnt[0];
        rwb_v[0] = 1'b0;
        addr_v[0] = 7'h40;
        wdata_v[0] = 16'h8001;
        start_v[0] = 1'b1;
        push(0, 24'h808001, 16'h1234);
        push(0, 24'h808001, 16'h1234);
        n = 0;
        while (fall_cnt[0] < base_f + 2 && n < 2000) begin
            tick();
            n++;
        end
        start_v[0] = 1'b0;
        chk("b2b_frames_started", 0, fall_cnt[0] - base_f, 2);
        wait_done(0, base_d + 2);

        send(0, 1'b0, 7'h11, 16'hFFFF, 16'h0000, 24'h22FFFF, 16'h1234);
        base_d = done_cnt[0];
        wait_rise(0, 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        chk("midreset_csz", 0, csz_w[0], 1);
        chk("midreset_sclk", 0, sclk_w[0], 0);
        chk("midreset_sdi", 0, sdi_w[0], 1);
        chk("midreset_busy", 0, busy_w[0], 0);
        chk("midreset_done", 0, done_w[0], 0);
        chk("midreset_rdata", 0, rdata_w[0], 16'h0000);
        repeat (250) tick();
        chk("no_done_after_reset", 0, done_cnt[0], base_d);
        frame(0, 1'b0, 7'h01, 16'h1234, 16'h0000, 24'h021234, 16'h0000);

`ifdef SPI_MASTER_ABORT_EN
        send(0, 1'b1, 7'h2B, 16'h0000, 16'h5555, 24'h57FFFF, 16'h0000);
        base_d = done_cnt[0];
        wait_rise(0, 20);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        chk("abort_pulse", 0, aborted_w[0], 1);
        chk("abort_csz", 0, csz_w[0], 1);
        chk("abort_sclk", 0, sclk_w[0], 0);
        chk("abort_sdi", 0, sdi_w[0], 1);
        chk("abort_busy", 0, busy_w[0], 1);
        chk("abort_rdata", 0, rdata_w[0], 16'h0000);
        chk("abort_other_quiet", 1, aborted_w[1], 0);
        tick();
        chk("abort_pulse_end", 0, aborted_w[0], 0);
        wait_idle(0);
        chk("no_done_after_abort", 0, done_cnt[0], base_d);
`endif

        frame(1, 1'b1, 7'h2A, 16'h0000, 16'hFFFF, 24'h55FFFF, 16'hFFFF);
        frame(1, 1'b1, 7'h2A, 16'h0000, 16'h0000, 24'h55FFFF, 16'h0000);
        repeat (20) tick();
        chk("scoreboard_drained", 0, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
